// File: rtl/seq_mult_ctrl_if.sv
// Handshake and external-adder bus for seq_mult_ctrl.
// The controller takes the slave modport; the requester and adder take the master modport.
interface seq_mult_ctrl_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic [3:0] add_sum;
  logic       add_cout;
  logic       busy;
  logic       done;
  logic [7:0] product;

  modport master (
    output start, A, B, add_sum, add_cout,
    input  add_a, add_b, busy, done, product
  );

  modport slave (
    input  start, A, B, add_sum, add_cout,
    output add_a, add_b, busy, done, product
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// 4x4 unsigned shift-add multiplier controller driving an external 4-bit adder.
// Optional MULT_ZERO_BYPASS_EN: a zero operand skips RUN and goes straight to DONE.
module seq_mult_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  seq_mult_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  logic [3:0] add_a_c, add_b_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    add_a_c   = '0;
    add_b_c   = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          m_d   = bus.A;
          q_d   = bus.B;
          cnt_d = '0;
`ifdef MULT_ZERO_BYPASS_EN
          if (bus.A == 4'd0 || bus.B == 4'd0) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d   = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        add_a_c = acc_q;
        add_b_c = q_q[0] ? m_q : '0;
        // Carry-out lands in bit 7 of {acc,q} as the pair shifts right.
        {acc_d, q_d} = {bus.add_cout, bus.add_sum, q_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = {bus.add_cout, bus.add_sum, q_q[3:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.add_a   = add_a_c;
  assign bus.add_b   = add_b_c;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl; models the external 4-bit adder combinationally.
// Expectations follow MULT_ZERO_BYPASS_EN when it is defined for the build.
module tb_seq_mult_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  logic [7:0] prev_prod;

  seq_mult_ctrl_if bus ();

  seq_mult_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one multiply and watch 8 cycles; hold keeps start=1 with A=B=1 during RUN.
  task automatic mult(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                      input bit hold, input string tag);
    int busy_n;
    int done_n;
    int done_at;
    bit zbyp;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
`ifdef MULT_ZERO_BYPASS_EN
    zbyp = (a == 4'd0) || (b == 4'd0);
`else
    zbyp = 1'b0;
`endif
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      bus.A = 4'd1;
      bus.B = 4'd1;
    end else begin
      bus.start = 1'b0;
    end
    if (!zbyp) check({tag, " held_product"}, bus.product, prev_prod);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    check({tag, " product"}, bus.product, exp);
    check({tag, " busy_cycles"}, 8'(busy_n), zbyp ? 8'd0 : 8'd4);
    check({tag, " done_count"}, 8'(done_n), 8'd1);
    check({tag, " done_latency"}, 8'(done_at), zbyp ? 8'd0 : 8'd4);
    prev_prod = exp;
  endtask

  initial begin
    int done_n;
    n_checks  = 0;
    n_fails   = 0;
    prev_prod = 8'h00;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.A     = 4'd5;
    bus.B     = 4'd5;

    // Reset held with start asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", {7'd0, bus.busy}, 8'd0);
    check("rst done", {7'd0, bus.done}, 8'd0);
    check("rst product", bus.product, 8'h00);
    check("rst add_a", {4'd0, bus.add_a}, 8'd0);
    check("rst add_b", {4'd0, bus.add_b}, 8'd0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_rst busy", {7'd0, bus.busy}, 8'd0);

    // First RUN cycle adder operands for 12*3 (q[0]=1 -> add_b=m)
    @(negedge clk);
    bus.A = 4'd12;
    bus.B = 4'd3;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("run0 add_a", {4'd0, bus.add_a}, 8'd0);
    check("run0 add_b", {4'd0, bus.add_b}, 8'd12);
    repeat (6) @(negedge clk);
    check("12x3 product", bus.product, 8'h24);
    check("idle add_b", {4'd0, bus.add_b}, 8'd0);
    prev_prod = 8'h24;

    mult(4'd12, 4'd3,  8'h24, 1'b0, "12x3");
    mult(4'd15, 4'd15, 8'hE1, 1'b0, "15x15");
    mult(4'd0,  4'd9,  8'h00, 1'b0, "0x9");
    mult(4'd5,  4'd13, 8'h41, 1'b1, "5x13_hold");

    // Reset at the second RUN cycle of 14*7
    @(negedge clk);
    bus.A = 4'd14;
    bus.B = 4'd7;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("abort busy_run", {7'd0, bus.busy}, 8'd1);
    check("abort add_b", {4'd0, bus.add_b}, 8'd14);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort busy", {7'd0, bus.busy}, 8'd0);
    check("abort done", {7'd0, bus.done}, 8'd0);
    check("abort product", bus.product, 8'h00);
    rst_n = 1'b1;
    prev_prod = 8'h00;
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("abort no_done", 8'(done_n), 8'd0);
    mult(4'd1, 4'd1, 8'h01, 1'b0, "1x1");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mult(4'(a), 4'(b), 8'(a * b), 1'b0, $sformatf("exh %0dx%0d", a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
